// File: rtl/capture_buffer_pkg.sv
// Shared definitions for the multi-channel capture buffer: register map,
// STATUS bit positions and the STATUS word layout.
package capture_buffer_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_WRPTR  = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_UDF   = 2;
  localparam int ST_OVF   = 3;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic full;
    logic empty;
  } status_t;

endpackage

// File: rtl/capture_buffer_mc_ram.sv
// Simple dual-port sample RAM with registered read data; read-during-write
// to the same address returns the old contents.
module capture_buffer_mc_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/capture_buffer_mc.sv
// NUM_CH circular capture FIFOs filled by datapath strobes and drained by a
// CPU slave port with a fixed two-cycle read latency.
module capture_buffer_mc
  import capture_buffer_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 8192,
  parameter int                OVERWRITE  = 0,
  parameter logic [DATA_W-1:0] EMPTY_WORD = 32'h0000_00FF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*DATA_W-1:0]     wr_data,
  input  logic [NUM_CH-1:0]            clear,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic [$clog2(NUM_CH)+2-1:0]  address,
  output logic [DATA_W-1:0]            readdata,
  output logic                         readdatavalid
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  // Read port: a request is taken whenever chipselect && read is high at a
  // clock edge; there is no stall. readdatavalid pulses for one cycle exactly
  // two cycles after acceptance, with readdata valid in that same cycle.
  logic              rd_acc;
  logic [1:0]        reg_sel;
  logic [ADDR_W-1:0] ch_full;
  logic [CH_W-1:0]   ch_sel;
  logic              ch_ok;

  assign rd_acc  = chipselect && read;
  assign reg_sel = address[1:0];
  assign ch_full = address >> 2;
  assign ch_sel  = ch_full[CH_W-1:0];
  assign ch_ok   = ch_full < ADDR_W'(NUM_CH);

  logic [PTR_W:0]    cnt_a [NUM_CH];
  logic [PTR_W-1:0]  wp_a  [NUM_CH];
  status_t           st_a  [NUM_CH];
  logic [DATA_W-1:0] q_a   [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic hit, empty, full, data_rd, pop, udf_set, stat_rd;
    logic ovr, wr_ok, inc, ovf_set;

    assign hit     = rd_acc && ch_ok && (ch_sel == CH_W'(c));
    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign data_rd = hit && (reg_sel == REG_DATA) && !clear[c];
    assign pop     = data_rd && !empty;
    assign udf_set = data_rd && empty;
    assign stat_rd = hit && (reg_sel == REG_STATUS);
    // A same-cycle pop frees the slot, so only an unpopped full write overflows.
    assign ovf_set = wr_en[c] && full && !pop;
    assign ovr     = ovf_set && (OVERWRITE != 0);
    assign wr_ok   = wr_en[c] && !clear[c] && (!full || pop || (OVERWRITE != 0));
    assign inc     = wr_ok && !ovr;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (clear[c]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop || ovr);
        count_d  = count_q + (PTR_W+1)'(inc) - (PTR_W+1)'(pop);
        ovf_d    = (ovf_q && !stat_rd) || ovf_set;
        udf_d    = (udf_q && !stat_rd) || udf_set;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
      end
    end

    capture_buffer_mc_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
    ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (wr_ok),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data[c*DATA_W +: DATA_W]),
      .rd_en_i   (pop),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (q_a[c])
    );

    assign cnt_a[c] = count_q;
    assign wp_a[c]  = wr_ptr_q;
    assign st_a[c]  = '{ovf: ovf_q, udf: udf_q, full: full, empty: empty};
  end

  // Stage 1 holds either an immediate register value sampled at acceptance
  // or a marker telling stage 2 to take the channel's RAM output.
  logic              s1_valid_q, s1_valid_d;
  logic              s1_ram_q, s1_ram_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
  logic [DATA_W-1:0] s1_imm_q, s1_imm_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readdatavalid_q, readdatavalid_d;

  always_comb begin
    s1_valid_d = rd_acc;
    s1_ram_d   = 1'b0;
    s1_ch_d    = ch_sel;
    s1_imm_d   = EMPTY_WORD;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ok && ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_DATA:   s1_ram_d = (cnt_a[i] != '0) && !clear[i];
          REG_COUNT:  s1_imm_d = DATA_W'(cnt_a[i]);
          REG_STATUS: s1_imm_d = DATA_W'(st_a[i]);
          default:    s1_imm_d = DATA_W'(wp_a[i]);
        endcase
      end
    end
  end

  always_comb begin
    readdata_d      = readdata_q;
    readdatavalid_d = s1_valid_q;
    if (s1_valid_q) begin
      readdata_d = s1_imm_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s1_ram_q && s1_ch_q == CH_W'(i)) readdata_d = q_a[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q      <= 1'b0;
      s1_ram_q        <= 1'b0;
      s1_ch_q         <= '0;
      s1_imm_q        <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_ram_q        <= s1_ram_d;
      s1_ch_q         <= s1_ch_d;
      s1_imm_q        <= s1_imm_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_capture_buffer_mc.sv
// Bench for capture_buffer_mc: drop-mode and overwrite-mode instances share
// stimulus and are each checked against a queue-based channel model.
module tb_capture_buffer_mc;
  import capture_buffer_pkg::*;

  localparam int NCH = 5;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = $clog2(NCH) + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCH-1:0]    wr_en, clear;
  logic [NCH*DW-1:0] wr_data;
  logic              chipselect, read;
  logic [AW-1:0]     address;
  logic [DW-1:0]     readdata0, readdata1;
  logic              rdv0, rdv1;

  capture_buffer_mc #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .OVERWRITE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .chipselect(chipselect), .read(read), .address(address),
    .readdata(readdata0), .readdatavalid(rdv0));

  capture_buffer_mc #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .OVERWRITE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .chipselect(chipselect), .read(read), .address(address),
    .readdata(readdata1), .readdatavalid(rdv1));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mq [2][NCH][$];
  int            wp [2][NCH];
  bit            mo [2][NCH];
  bit            mu [2][NCH];
  logic [DW-1:0] exp_q   [2][$];
  int            exp_cyc [2][$];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) begin
        mq[m][c].delete();
        wp[m][c] = 0;
        mo[m][c] = 1'b0;
        mu[m][c] = 1'b0;
      end
      exp_q[m].delete();
      exp_cyc[m].delete();
    end
  endtask

  // One cycle of channel behaviour: the read sees the pre-cycle state, then
  // writes and clears are applied.
  task automatic model_step(input int m);
    int ch, rg, n;
    logic [DW-1:0] resp;
    if (chipselect && read) begin
      ch = int'(address) >> 2;
      rg = int'(address) & 3;
      resp = 32'h0000_00FF;
      if (ch < NCH) begin
        n = mq[m][ch].size();
        case (rg)
          0: begin
            if (!clear[ch] && n > 0) resp = mq[m][ch].pop_front();
            else if (!clear[ch]) mu[m][ch] = 1'b1;
          end
          1: resp = n;
          2: begin
            resp = {28'd0, mo[m][ch], mu[m][ch], n == DEP, n == 0};
            mo[m][ch] = 1'b0;
            mu[m][ch] = 1'b0;
          end
          default: resp = wp[m][ch];
        endcase
      end
      exp_q[m].push_back(resp);
      exp_cyc[m].push_back(cyc + 2);
    end
    for (int c = 0; c < NCH; c++) begin
      if (clear[c]) begin
        mq[m][c].delete();
        wp[m][c] = 0;
        mo[m][c] = 1'b0;
        mu[m][c] = 1'b0;
      end else if (wr_en[c]) begin
        if (mq[m][c].size() < DEP) begin
          mq[m][c].push_back(wr_data[c*DW +: DW]);
          wp[m][c] = (wp[m][c] + 1) % DEP;
        end else begin
          mo[m][c] = 1'b1;
          if (m == 1) begin
            void'(mq[m][c].pop_front());
            mq[m][c].push_back(wr_data[c*DW +: DW]);
            wp[m][c] = (wp[m][c] + 1) % DEP;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int m, input logic v, input logic [DW-1:0] d);
    if (v) begin
      if (exp_q[m].size() == 0) begin
        check_eq($sformatf("dut%0d_spurious_valid", m), 32'(v), 32'd0);
      end else begin
        check_eq($sformatf("dut%0d_latency", m), cyc, exp_cyc[m][0]);
        check_eq($sformatf("dut%0d_readdata", m), d, exp_q[m][0]);
        void'(exp_q[m].pop_front());
        void'(exp_cyc[m].pop_front());
      end
    end else if (exp_q[m].size() > 0 && exp_cyc[m][0] <= cyc) begin
      check_eq($sformatf("dut%0d_missing_valid", m), 32'(v), 32'd1);
      void'(exp_q[m].pop_front());
      void'(exp_cyc[m].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      mon(0, rdv0, readdata0);
      mon(1, rdv1, readdata1);
    end else if (reset_n === 1'b0) begin
      check_eq("rst_valid0", 32'(rdv0), 32'd0);
      check_eq("rst_valid1", 32'(rdv1), 32'd0);
      check_eq("rst_data0", readdata0, 32'd0);
      check_eq("rst_data1", readdata1, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [AW-1:0] ra(input int ch, input int rg);
    return AW'(ch * 4 + rg);
  endfunction

  task automatic drive(input logic [NCH-1:0] we, input logic [NCH*DW-1:0] wd,
                       input logic [NCH-1:0] clr, input logic cs, input logic rd,
                       input logic [AW-1:0] a);
    wr_en = we; wr_data = wd; clear = clr;
    chipselect = cs; read = rd; address = a;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    wr_en = '0; clear = '0; chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr1(input int ch, input logic [DW-1:0] d);
    logic [NCH*DW-1:0] wd;
    wd = '0;
    wd[ch*DW +: DW] = d;
    drive(NCH'(1) << ch, wd, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd1(input int ch, input int rg);
    drive('0, '0, '0, 1'b1, 1'b1, ra(ch, rg));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Whole-run guard so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NCH-1:0]    we, clr;
    logic [NCH*DW-1:0] wd;
    int wprob;
    reset_n = 1'b0;
    wr_en = '0; clear = '0; wr_data = '0;
    chipselect = 1'b0; read = 1'b0; address = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // ch1: three samples drained back-to-back
    wr1(1, 32'hA); wr1(1, 32'hB); wr1(1, 32'hC);
    rd1(1, REG_DATA); rd1(1, REG_DATA); rd1(1, REG_DATA);
    rd1(1, REG_COUNT); rd1(1, REG_STATUS);

    // empty read on ch0 and read-to-clear of udf
    rd1(0, REG_DATA); rd1(0, REG_COUNT); rd1(0, REG_STATUS); rd1(0, REG_STATUS);

    // ch2: one sample past full, then drain
    for (int i = 0; i <= DEP; i++) wr1(2, 32'(i));
    rd1(2, REG_COUNT); rd1(2, REG_STATUS);
    for (int i = 0; i < DEP; i++) rd1(2, REG_DATA);
    rd1(2, REG_STATUS);

    // ch3 full: write and pop in the same cycle
    for (int i = 0; i < DEP; i++) wr1(3, 32'h300 + 32'(i));
    wd = '0;
    wd[3*DW +: DW] = 32'h3FF;
    drive(NCH'(1) << 3, wd, '0, 1'b1, 1'b1, ra(3, REG_DATA));
    rd1(3, REG_COUNT); rd1(3, REG_STATUS); rd1(3, REG_WRPTR);

    // ch0 clear with a simultaneous DATA read
    for (int i = 0; i < 5; i++) wr1(0, 32'h100 + 32'(i));
    drive('0, '0, NCH'(1), 1'b1, 1'b1, ra(0, REG_DATA));
    rd1(0, REG_COUNT); rd1(0, REG_STATUS); rd1(3, REG_COUNT); rd1(1, REG_WRPTR);

    // invalid channel reads, then CPU read with chipselect low
    rd1(6, REG_DATA); rd1(7, REG_STATUS);
    drive('0, '0, '0, 1'b0, 1'b1, ra(3, REG_DATA));
    rd1(3, REG_COUNT);
    idle(3);

    // reset while a DATA read is in flight
    for (int i = 0; i < 4; i++) wr1(4, 32'h400 + 32'(i));
    rd1(4, REG_DATA);
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd1(4, REG_COUNT); rd1(4, REG_WRPTR); rd1(3, REG_COUNT);
    idle(3);

    // randomized traffic: alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      wprob = ((i / 300) % 2 == 0) ? 40 : 3;
      we = '0; clr = '0; wd = '0;
      for (int c = 0; c < NCH; c++) begin
        we[c] = ($urandom_range(99) < wprob);
        clr[c] = ($urandom_range(299) == 0);
        wd[c*DW +: DW] = $urandom;
      end
      drive(we, wd, clr, $urandom_range(9) != 0, $urandom_range(9) < 7,
            ra($urandom_range(0, 7),
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0));
    end
    idle(5);
    check_eq("exp_drained0", exp_q[0].size(), 32'd0);
    check_eq("exp_drained1", exp_q[1].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
